match_turn_controller: RTL and testbench

//   Turn sequencer for the 4x4 card-flip memory game. Accepts cursor/select events from the

---
 rtl/card_game_pkg.sv | 25 ++
 rtl/hold_timer.sv | 38 +++
 rtl/match_turn_controller.sv | 198 +++++++++++++++++++
 tb/tb_match_turn_controller.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_game_pkg.sv
// Shared definitions for the card-flip memory game: card state encoding,
// turn sequencer state encoding and default board geometry.
package card_game_pkg;

    // Default board geometry: 16 cards, 8 symbols, 2 cards per symbol.
    localparam int DEF_NUM_CARDS = 16;
    localparam int DEF_SYM_W     = 3;

    // Per-card display state. The encoding 2'b11 is never produced.
    typedef logic [1:0] card_state_t;

    localparam card_state_t CARD_HIDDEN  = 2'b00;
    localparam card_state_t CARD_FLIPPED = 2'b01;
    localparam card_state_t CARD_MATCHED = 2'b10;

    // Turn sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,    // waiting for the first flip of a turn
        ST_ONE_UP,  // one card face up, waiting for the second flip
        ST_CHECK,   // single cycle symbol comparison
        ST_HOLD,    // mismatched pair held face up, input locked
        ST_WON      // all pairs found, waiting for new_game/reset
    } turn_state_t;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times the mismatch reveal. Once loaded it
// counts while `count` is high and flags `expire` during the last cycle.
module hold_timer #(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LAST_VALUE = CNT_W'(1);

    logic [CNT_W-1:0] remaining;

    // Remaining hold cycles: cleared, reloaded, or decremented toward zero.
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= LOAD_VALUE;
        end else if (count && (remaining != '0)) begin
            remaining <= remaining - LAST_VALUE;
        end
    end

    // The final counted cycle is the one in which the count reads 1.
    assign expire = count && (remaining == LAST_VALUE);

endmodule

// File: rtl/match_turn_controller.sv
// Turn sequencer for the 4x4 card-flip memory game. Owns the per-card state
// vector, runs first flip -> second flip -> compare -> hold -> resolve, and
// keeps the move/pair counters and the win flag for the display layer.
module match_turn_controller
    import card_game_pkg::*;
#(
    parameter int NUM_CARDS   = DEF_NUM_CARDS,
    parameter int SYM_W       = DEF_SYM_W,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int MOVE_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_game,
    input  logic                       select_pulse,
    input  logic [3:0]                 cursor_pos,
    input  logic [NUM_CARDS*SYM_W-1:0] card_values,
    output logic [2*NUM_CARDS-1:0]     card_states,
    output logic                       input_lock,
    output logic [MOVE_W-1:0]          move_count,
    output logic [3:0]                 pairs_matched,
    output logic                       match_pulse,
    output logic                       mismatch_pulse,
    output logic                       game_won
);

    localparam int               IDX_W       = $clog2(NUM_CARDS);
    localparam logic [3:0]       PAIRS_TOTAL = 4'(NUM_CARDS / 2);
    localparam logic [3:0]       PAIR_ONE    = 4'd1;
    localparam logic [MOVE_W-1:0] MOVE_ONE   = MOVE_W'(1);
    localparam logic [MOVE_W-1:0] MOVE_MAX   = {MOVE_W{1'b1}};

    turn_state_t      state;
    card_state_t      cards [NUM_CARDS];
    logic [SYM_W-1:0] syms  [NUM_CARDS];
    logic [IDX_W-1:0] first_pos;
    logic [IDX_W-1:0] second_pos;
    logic [IDX_W-1:0] cursor_idx;

    logic cursor_in_range;
    logic sel_hidden;
    logic accept_first;
    logic accept_second;
    logic resolve_match;
    logic resolve_mismatch;
    logic hold_count;
    logic hold_expire;

    // Unpack the symbol bus and pack the card states for the display layer.
    for (genvar i = 0; i < NUM_CARDS; i++) begin : g_card
        assign syms[i]               = card_values[i*SYM_W +: SYM_W];
        assign card_states[2*i +: 2] = cards[i];
    end

    // Turn decisions shared by the FSM and the card state update.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        cursor_in_range  = 1'b0;
        cursor_idx       = '0;
        sel_hidden       = 1'b0;
        accept_first     = 1'b0;
        accept_second    = 1'b0;
        resolve_match    = 1'b0;
        resolve_mismatch = 1'b0;
        hold_count       = 1'b0;

        cursor_in_range = int'(cursor_pos) < NUM_CARDS;
        cursor_idx      = IDX_W'(cursor_pos);
        sel_hidden      = select_pulse && !new_game && cursor_in_range &&
                          (cards[cursor_idx] == CARD_HIDDEN);

        accept_first  = sel_hidden && (state == ST_IDLE);
        accept_second = sel_hidden && (state == ST_ONE_UP) &&
                        (cursor_idx != first_pos);

        if (!new_game && (state == ST_CHECK)) begin
            resolve_match    = (syms[first_pos] == syms[second_pos]);
            resolve_mismatch = !resolve_match;
        end
        hold_count = !new_game && (state == ST_HOLD);
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (new_game),
        .load   (resolve_mismatch),
        .count  (hold_count),
        .expire (hold_expire)
    );

    // Turn FSM with registered counters, pulses, lock and win flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            first_pos      <= '0;
            second_pos     <= '0;
            move_count     <= '0;
            pairs_matched  <= '0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            game_won       <= 1'b0;
            input_lock     <= 1'b0;
        end else begin
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            if (new_game) begin
                state         <= ST_IDLE;
                first_pos     <= '0;
                second_pos    <= '0;
                move_count    <= '0;
                pairs_matched <= '0;
                game_won      <= 1'b0;
                input_lock    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept_first) begin
                            first_pos <= cursor_idx;
                            state     <= ST_ONE_UP;
                        end
                    end
                    ST_ONE_UP: begin
                        if (accept_second) begin
                            second_pos <= cursor_idx;
                            if (move_count != MOVE_MAX) begin
                                move_count <= move_count + MOVE_ONE;
                            end
                            input_lock <= 1'b1;
                            state      <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (resolve_match) begin
                            pairs_matched <= pairs_matched + PAIR_ONE;
                            match_pulse   <= 1'b1;
                            if ((pairs_matched + PAIR_ONE) == PAIRS_TOTAL) begin
                                game_won <= 1'b1;
                                state    <= ST_WON;
                            end else begin
                                input_lock <= 1'b0;
                                state      <= ST_IDLE;
                            end
                        end else begin
                            mismatch_pulse <= 1'b1;
                            state          <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_expire) begin
                            input_lock <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_WON: begin
                        game_won   <= 1'b1;
                        input_lock <= 1'b1;
                    end
                    default: begin
                        input_lock <= 1'b0;
                        state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Card state vector: flips on accepted selects, resolves after compare/hold.
    // NOTE: the card array is a small register file read by the display, so
    // every entry is reset explicitly rather than left to power-up contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                cards[i] <= CARD_HIDDEN;
            end
        end else if (new_game) begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                cards[i] <= CARD_HIDDEN;
            end
        end else begin
            if (accept_first || accept_second) begin
                cards[cursor_idx] <= CARD_FLIPPED;
            end
            if (resolve_match) begin
                cards[first_pos]  <= CARD_MATCHED;
                cards[second_pos] <= CARD_MATCHED;
            end
            if (hold_expire) begin
                cards[first_pos]  <= CARD_HIDDEN;
                cards[second_pos] <= CARD_HIDDEN;
            end
        end
    end

endmodule

// File: tb/tb_match_turn_controller.sv
// Self-checking bench for match_turn_controller: table-driven pair attempts,
// hand-written timing sequences, and a scoreboard for match/mismatch pulses.
module tb_match_turn_controller;

    localparam int NUM_CARDS   = 16;
    localparam int SYM_W       = 3;
    localparam int HOLD_CYCLES = 4;
    localparam int MOVE_W      = 8;

    logic                       clk;
    logic                       reset;
    logic                       new_game;
    logic                       select_pulse;
    logic [3:0]                 cursor_pos;
    logic [NUM_CARDS*SYM_W-1:0] card_values;
    logic [2*NUM_CARDS-1:0]     card_states;
    logic                       input_lock;
    logic [MOVE_W-1:0]          move_count;
    logic [3:0]                 pairs_matched;
    logic                       match_pulse;
    logic                       mismatch_pulse;
    logic                       game_won;

    match_turn_controller #(
        .NUM_CARDS  (NUM_CARDS),
        .SYM_W      (SYM_W),
        .HOLD_CYCLES(HOLD_CYCLES),
        .MOVE_W     (MOVE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .new_game      (new_game),
        .select_pulse  (select_pulse),
        .cursor_pos    (cursor_pos),
        .card_values   (card_values),
        .card_states   (card_states),
        .input_lock    (input_lock),
        .move_count    (move_count),
        .pairs_matched (pairs_matched),
        .match_pulse   (match_pulse),
        .mismatch_pulse(mismatch_pulse),
        .game_won      (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_match;
        int due;
    } event_t;

    event_t sb[$];

    typedef struct {
        int a;
        int b;
        bit is_match;
        int pairs;
        int moves;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] card(input int i);
        return card_states[2*i +: 2];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ev: 0 = no turn result expected, 1 = match expected, 2 = mismatch expected
    task automatic select_card(input int p, input int ev);
        event_t e;
        select_pulse = 1'b1;
        cursor_pos   = 4'(p);
        if (ev != 0) begin
            e.is_match = (ev == 1);
            e.due      = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        select_pulse = 1'b0;
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
    endtask

    // Scoreboard: every pulse must match the oldest expected result and cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (match_pulse || mismatch_pulse) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, match_pulse, mismatch_pulse}, 32'd0);
                end else begin
                    event_t e;
                    e = sb.pop_front();
                    check("pulse_kind", 32'(match_pulse), 32'(e.is_match));
                    check("pulse_cycle", cyc, e.due);
                    check("pulse_exclusive", 32'(match_pulse & mismatch_pulse), 32'd0);
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                event_t e;
                e = sb.pop_front();
                check("missing_pulse", cyc, e.due);
            end
        end
    end

    initial begin
        vecs[0]  = '{a: 0,  b: 1,  is_match: 1'b1, pairs: 1, moves: 1};
        vecs[1]  = '{a: 2,  b: 4,  is_match: 1'b0, pairs: 1, moves: 2};
        vecs[2]  = '{a: 2,  b: 3,  is_match: 1'b1, pairs: 2, moves: 3};
        vecs[3]  = '{a: 4,  b: 6,  is_match: 1'b0, pairs: 2, moves: 4};
        vecs[4]  = '{a: 5,  b: 4,  is_match: 1'b1, pairs: 3, moves: 5};
        vecs[5]  = '{a: 6,  b: 7,  is_match: 1'b1, pairs: 4, moves: 6};
        vecs[6]  = '{a: 15, b: 8,  is_match: 1'b0, pairs: 4, moves: 7};
        vecs[7]  = '{a: 8,  b: 9,  is_match: 1'b1, pairs: 5, moves: 8};
        vecs[8]  = '{a: 10, b: 11, is_match: 1'b1, pairs: 6, moves: 9};
        vecs[9]  = '{a: 13, b: 12, is_match: 1'b1, pairs: 7, moves: 10};
        vecs[10] = '{a: 14, b: 15, is_match: 1'b1, pairs: 8, moves: 11};

        for (int i = 0; i < NUM_CARDS; i++) begin
            card_values[i*SYM_W +: SYM_W] = 3'(i >> 1);
        end
        reset        = 1'b1;
        new_game     = 1'b0;
        select_pulse = 1'b0;
        cursor_pos   = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1. Reset state
        check("rst_cards", card_states, 32'd0);
        check("rst_moves", 32'(move_count), 32'd0);
        check("rst_pairs", 32'(pairs_matched), 32'd0);
        check("rst_won", 32'(game_won), 32'd0);
        check("rst_lock", 32'(input_lock), 32'd0);

        // 2. Matching pair with exact latency
        select_card(0, 0);
        check("m_card0_flip", 32'(card(0)), 32'd1);
        check("m_lock_one_up", 32'(input_lock), 32'd0);
        select_card(1, 1);
        check("m_card1_flip", 32'(card(1)), 32'd1);
        check("m_lock_check", 32'(input_lock), 32'd1);
        check("m_no_early_pulse", 32'(match_pulse), 32'd0);
        step();
        check("m_card0_matched", 32'(card(0)), 32'd2);
        check("m_card1_matched", 32'(card(1)), 32'd2);
        check("m_pulse", 32'(match_pulse), 32'd1);
        check("m_pairs", 32'(pairs_matched), 32'd1);
        check("m_moves", 32'(move_count), 32'd1);
        check("m_lock_after", 32'(input_lock), 32'd0);
        step();
        check("m_pulse_one_cycle", 32'(match_pulse), 32'd0);

        // 3. Mismatch, hold timing, select ignored during hold
        start_new_game();
        select_card(0, 0);
        select_card(2, 2);
        check("mm_lock_check", 32'(input_lock), 32'd1);
        check("mm_moves", 32'(move_count), 32'd1);
        step();
        check("mm_pulse", 32'(mismatch_pulse), 32'd1);
        check("mm_hold1_c0", 32'(card(0)), 32'd1);
        check("mm_hold1_c2", 32'(card(2)), 32'd1);
        select_card(5, 0);
        for (int h = 2; h <= HOLD_CYCLES; h++) begin
            check($sformatf("mm_hold%0d_c0", h), 32'(card(0)), 32'd1);
            check($sformatf("mm_hold%0d_c2", h), 32'(card(2)), 32'd1);
            check($sformatf("mm_hold%0d_lock", h), 32'(input_lock), 32'd1);
            if (h < HOLD_CYCLES) step();
        end
        step();
        check("mm_hidden_c0", 32'(card(0)), 32'd0);
        check("mm_hidden_c2", 32'(card(2)), 32'd0);
        check("mm_sel5_ignored", 32'(card(5)), 32'd0);
        check("mm_lock_release", 32'(input_lock), 32'd0);
        check("mm_moves_after", 32'(move_count), 32'd1);
        check("mm_pairs_after", 32'(pairs_matched), 32'd0);
        select_card(4, 0);
        check("mm_first_idle_select", 32'(card(4)), 32'd1);

        // 4. Re-selecting the first card is ignored; turn continues
        start_new_game();
        check("ng_clears_one_up", card_states, 32'd0);
        select_card(3, 0);
        select_card(3, 0);
        check("dup_card3", 32'(card(3)), 32'd1);
        check("dup_lock", 32'(input_lock), 32'd0);
        check("dup_moves", 32'(move_count), 32'd0);
        select_card(2, 1);
        step();
        check("dup_pair_cards", card_states[7:4], 32'hA);
        check("dup_pairs", 32'(pairs_matched), 32'd1);
        check("dup_moves_after", 32'(move_count), 32'd1);

        // new_game during CHECK aborts the turn without a pulse
        start_new_game();
        select_card(0, 0);
        select_card(1, 0);
        start_new_game();
        check("abort_cards", card_states, 32'd0);
        check("abort_pairs", 32'(pairs_matched), 32'd0);
        check("abort_moves", 32'(move_count), 32'd0);

        // new_game and select together: select dropped
        new_game     = 1'b1;
        select_pulse = 1'b1;
        cursor_pos   = 4'd6;
        step();
        new_game     = 1'b0;
        select_pulse = 1'b0;
        check("ng_beats_select", 32'(card(6)), 32'd0);
        check("ng_beats_select_lock", 32'(input_lock), 32'd0);

        // 5. Table-driven full game to a win
        start_new_game();
        for (int i = 0; i < $size(vecs); i++) begin
            select_card(vecs[i].a, 0);
            select_card(vecs[i].b, vecs[i].is_match ? 1 : 2);
            check($sformatf("v%0d_b_flip", i), 32'(card(vecs[i].b)), 32'd1);
            check($sformatf("v%0d_lock_check", i), 32'(input_lock), 32'd1);
            check($sformatf("v%0d_moves", i), 32'(move_count), 32'(vecs[i].moves));
            step();
            check($sformatf("v%0d_a_res", i), 32'(card(vecs[i].a)), vecs[i].is_match ? 32'd2 : 32'd1);
            check($sformatf("v%0d_b_res", i), 32'(card(vecs[i].b)), vecs[i].is_match ? 32'd2 : 32'd1);
            check($sformatf("v%0d_pairs", i), 32'(pairs_matched), 32'(vecs[i].pairs));
            if (!vecs[i].is_match) begin
                repeat (HOLD_CYCLES) step();
                check($sformatf("v%0d_a_hidden", i), 32'(card(vecs[i].a)), 32'd0);
                check($sformatf("v%0d_b_hidden", i), 32'(card(vecs[i].b)), 32'd0);
            end
            check($sformatf("v%0d_lock", i), 32'(input_lock), (vecs[i].pairs == NUM_CARDS / 2) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_won", i), 32'(game_won), (vecs[i].pairs == NUM_CARDS / 2) ? 32'd1 : 32'd0);
        end
        select_card(3, 0);
        select_card(9, 0);
        step();
        check("won_cards", card_states, 32'hAAAA_AAAA);
        check("won_moves", 32'(move_count), 32'd11);
        check("won_pairs", 32'(pairs_matched), 32'd8);
        check("won_sticky", 32'(game_won), 32'd1);
        check("won_lock", 32'(input_lock), 32'd1);
        start_new_game();
        check("ng_cards", card_states, 32'd0);
        check("ng_moves", 32'(move_count), 32'd0);
        check("ng_pairs", 32'(pairs_matched), 32'd0);
        check("ng_won", 32'(game_won), 32'd0);
        check("ng_lock", 32'(input_lock), 32'd0);

        // 6a. Async reset mid-HOLD
        select_card(0, 0);
        select_card(2, 2);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("arst_cards", card_states, 32'd0);
        check("arst_moves", 32'(move_count), 32'd0);
        check("arst_lock", 32'(input_lock), 32'd0);
        check("arst_pulse", 32'(mismatch_pulse), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (HOLD_CYCLES + 2) step();
        check("arst_cards_later", card_states, 32'd0);
        check("arst_lock_later", 32'(input_lock), 32'd0);

        // 6b. Move counter saturation
        for (int k = 0; k < 256; k++) begin
            select_card(0, 0);
            select_card(2, 2);
            repeat (HOLD_CYCLES + 1) step();
        end
        check("sat_moves", 32'(move_count), 32'd255);
        check("sat_cards", card_states, 32'd0);

        repeat (3) step();
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout actual=%0d expected=finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
